nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/ADD_t.sv | 21 ++
 rtl/nibble_serial_adder_ctrl.sv | 108 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ADD_t.sv
// 4-bit ripple-carry adder slice, shared across all nibbles of a wide operand.
module ADD_t (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial add/subtract of a W-bit operand pair through one shared 4-bit slice,
// LSB nibble first, with valid/ready handshakes on operands and result.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*NIBBLES-1:0] in_a,
  input  logic [NIB_W*NIBBLES-1:0] in_b,
  input  logic                   in_cin,
  input  logic                   in_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*NIBBLES-1:0] out_sum,
  output logic                   out_cout,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [W-1:0]     a_reg, b_reg, sum_reg;
  logic [W-1:0]     sum_next;
  logic [NIB_W-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;
  logic             ovf_next;

  ADD_t u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    slice_a  = a_reg[idx_reg*NIB_W +: NIB_W];
    slice_b  = b_reg[idx_reg*NIB_W +: NIB_W];
    sum_next = sum_reg;
    sum_next[idx_reg*NIB_W +: NIB_W] = slice_sum;
    // Overflow uses the already-inverted B so subtract needs no special case.
    ovf_next = (a_reg[W-1] == b_reg[W-1]) && (sum_next[W-1] != a_reg[W-1]);
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (in_valid)             state_next = ST_RUN;
      ST_RUN:  if (idx_reg == IDX_LAST)  state_next = ST_DONE;
      ST_DONE: if (out_ready)            state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_sub ? ~in_b : in_b;
            carry_reg <= in_sub ? 1'b1 : in_cin;
            idx_reg   <= '0;
            sum_reg   <= '0;
          end
        end
        ST_RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= slice_cout;
          // Result ports only change on the final nibble so they hold during RUN.
          if (idx_reg == IDX_LAST) begin
            out_sum  <= sum_next;
            out_cout <= slice_cout;
            out_ovf  <= ovf_next;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign busy      = (state_reg == ST_RUN);
  assign out_valid = (state_reg == ST_DONE);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed checks of the nibble-serial adder against an
// arithmetic reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain W+1-bit arithmetic on (A, B or ~B, carry-in).
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  // Called 1 time unit after a rising edge, DUT in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input int hold, input logic [W+1:0] exp);
    int lat;
    int busy_cnt;
    logic [W-1:0] s_hold;
    logic c_hold, o_hold;
    check("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (out_valid) break;
      if (busy) busy_cnt++;
    end
    check("latency", lat, NIBBLES);
    check("busy_cycles", busy_cnt, NIBBLES);
    check("sum", out_sum, exp[W-1:0]);
    check("cout", out_cout, exp[W]);
    check("ovf", out_ovf, exp[W+1]);
    $display("op a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             a, b, cin, sub, out_sum, out_cout, out_ovf, lat);
    s_hold = out_sum; c_hold = out_cout; o_hold = out_ovf;
    if (hold > 0) begin
      in_a = W'($urandom); in_b = W'($urandom); in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check("hold_valid", out_valid, 1);
        check("hold_ready", in_ready, 0);
        check("hold_sum", out_sum, s_hold);
        check("hold_flags", {out_cout, out_ovf}, {c_hold, o_hold});
      end
    end
    out_ready = 1'b1;
    check("no_bypass", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("exit_valid", out_valid, 0);
    check("exit_busy", busy, 0);
    check("idle_hold_sum", out_sum, s_hold);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rc, rs;
    #12;
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", out_sum, 0);
    check("rst_flags", {out_cout, out_ovf}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h4321, 0, 0, 0, {2'b00, 16'h5555});
    run_op(16'hFFFF, 16'h0001, 0, 0, 0, {2'b01, 16'h0000});
    run_op(16'hFFFF, 16'h0000, 1, 0, 0, {2'b01, 16'h0000});
    run_op(16'h7FFF, 16'h0001, 0, 0, 0, {2'b10, 16'h8000});
    run_op(16'h8000, 16'h0001, 0, 1, 0, {2'b11, 16'h7FFF});
    run_op(16'h0005, 16'h0007, 0, 1, 0, {2'b00, 16'hFFFE});
    run_op(16'h0005, 16'h0007, 1, 1, 5, {2'b00, 16'hFFFE});
    run_op(16'h0101, 16'h0202, 0, 0, 0, {2'b00, 16'h0303});

    // Asynchronous reset with the sequencer at nibble 2.
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 0; in_sub = 0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 1);
    check("arst_valid", out_valid, 0);
    check("arst_sum", out_sum, 0);
    check("arst_flags", {out_cout, out_ovf}, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("arst_no_pulse", out_valid, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0001, 0, 0, 0, {2'b00, 16'h0002});

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      run_op(ra, rb, rc, rs, int'($urandom_range(0, 2)), model(ra, rb, rc, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
